// File: rtl/dht_transaction_ctrl.sv
// DHT11/DHT22 single-wire transaction controller: host start pulse, response check,
// pulse-width bit decode and checksum. Define DHT_AUTO_RETRY_EN for up to 2 automatic retries.
module dht_transaction_ctrl #(
  parameter int unsigned TICK_PER_US     = 50,
  parameter int unsigned START_LOW_US    = 18000,
  parameter int unsigned RELEASE_US      = 30,
  parameter int unsigned RESP_TIMEOUT_US = 200,
  parameter int unsigned BIT_THRESH_US   = 48,
  parameter int unsigned NUM_BITS        = 40,
  parameter int unsigned US_CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dq_in,
  output logic                dq_oe,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic                err_checksum,
`ifdef DHT_AUTO_RETRY_EN
  output logic [1:0]          retry_cnt,
`endif
  output logic [NUM_BITS-1:0] data_out
);

  localparam int unsigned PRE_W     = (TICK_PER_US > 1) ? $clog2(TICK_PER_US) : 1;
  localparam int unsigned BIT_W     = $clog2(NUM_BITS + 1);
  localparam int unsigned NUM_BYTES = NUM_BITS / 8;

  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(TICK_PER_US - 1);
  localparam logic [US_CNT_W-1:0] START_LAST = US_CNT_W'(START_LOW_US - 1);
  localparam logic [US_CNT_W-1:0] RELEASE_T  = US_CNT_W'(RELEASE_US);
  localparam logic [US_CNT_W-1:0] TIMEOUT_T  = US_CNT_W'(RESP_TIMEOUT_US);
  localparam logic [US_CNT_W-1:0] THRESH_T   = US_CNT_W'(BIT_THRESH_US);
  localparam logic [BIT_W-1:0]    BITS_LAST  = BIT_W'(NUM_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_RELEASE,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic                  dq_meta_q, dq_meta_d;
  logic                  dq_s_q, dq_s_d;
  logic                  dq_prev_q, dq_prev_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [US_CNT_W-1:0]   us_q, us_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS-1:0]   shreg_q, shreg_d;
  logic [NUM_BITS-1:0]   data_q, data_d;
  logic                  err_to_q, err_to_d;
  logic                  err_ck_q, err_ck_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef DHT_AUTO_RETRY_EN
  logic [1:0]            retry_q, retry_d;
`endif

  logic                  rise, fall, us_tick, timeout, bit_val;
  logic                  to_fail, ck_fail;
  logic [7:0]            csum;

  always_comb begin : sync_path
    dq_meta_d = dq_in;
    dq_s_d    = dq_meta_q;
    dq_prev_d = dq_s_q;
    rise      = dq_s_q & ~dq_prev_q;
    fall      = ~dq_s_q & dq_prev_q;
  end

  always_comb begin : checksum
    csum = '0;
    for (int unsigned i = 1; i < NUM_BYTES; i++) begin
      csum = csum + shreg_q[NUM_BITS-8*i +: 8];
    end
  end

  always_comb begin : fsm
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    err_to_d  = err_to_q;
    err_ck_d  = err_ck_q;
`ifdef DHT_AUTO_RETRY_EN
    retry_d   = retry_q;
`endif
    to_fail   = 1'b0;
    ck_fail   = 1'b0;
    us_tick   = (pre_q == PRE_LAST);
    timeout   = (us_q >= TIMEOUT_T);
    bit_val   = (us_q > THRESH_T);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_to_d  = 1'b0;
          err_ck_d  = 1'b0;
          bit_cnt_d = '0;
          shreg_d   = '0;
`ifdef DHT_AUTO_RETRY_EN
          retry_d   = '0;
`endif
          state_d   = S_START_LOW;
        end
      end
      S_START_LOW: begin
        if (us_tick && (us_q == START_LAST)) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Our own release produces edges on the line; only trust it after RELEASE_US.
        if (fall && (us_q >= RELEASE_T)) state_d = S_RESP_LOW;
        else if (timeout)                to_fail = 1'b1;
      end
      S_RESP_LOW: begin
        if (rise)         state_d = S_RESP_HIGH;
        else if (timeout) to_fail = 1'b1;
      end
      S_RESP_HIGH: begin
        if (fall)         state_d = S_BIT_LOW;
        else if (timeout) to_fail = 1'b1;
      end
      S_BIT_LOW: begin
        if (rise)         state_d = S_BIT_HIGH;
        else if (timeout) to_fail = 1'b1;
      end
      S_BIT_HIGH: begin
        if (fall) begin
          shreg_d   = {shreg_q[NUM_BITS-2:0], bit_val};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == BITS_LAST) ? S_CHECK : S_BIT_LOW;
        end else if (timeout) begin
          to_fail = 1'b1;
        end
      end
      S_CHECK: begin
        if (csum != shreg_q[7:0]) ck_fail = 1'b1;
        else                      state_d = S_FINISH;
      end
      S_FINISH: begin
        if (!err_to_q) data_d = shreg_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A failed attempt either restarts the start pulse (retry build) or ends the transaction.
    if (to_fail || ck_fail) begin
`ifdef DHT_AUTO_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d   = retry_q + 1'b1;
        err_to_d  = 1'b0;
        err_ck_d  = 1'b0;
        bit_cnt_d = '0;
        shreg_d   = '0;
        state_d   = S_START_LOW;
      end else
`endif
      begin
        err_to_d = to_fail;
        err_ck_d = ck_fail;
        state_d  = S_FINISH;
      end
    end

    if (state_d != state_q) begin
      pre_d = '0;
      us_d  = '0;
    end else begin
      pre_d = us_tick ? '0 : pre_q + 1'b1;
      us_d  = (us_tick && (us_q != '1)) ? us_q + 1'b1 : us_q;
    end

    dq_oe_d = (state_d == S_START_LOW);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dq_meta_q <= 1'b0;
      dq_s_q    <= 1'b0;
      dq_prev_q <= 1'b0;
      pre_q     <= '0;
      us_q      <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      err_to_q  <= 1'b0;
      err_ck_q  <= 1'b0;
      dq_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DHT_AUTO_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dq_meta_q <= dq_meta_d;
      dq_s_q    <= dq_s_d;
      dq_prev_q <= dq_prev_d;
      pre_q     <= pre_d;
      us_q      <= us_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      err_to_q  <= err_to_d;
      err_ck_q  <= err_ck_d;
      dq_oe_q   <= dq_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef DHT_AUTO_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign dq_oe        = dq_oe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_timeout  = err_to_q;
  assign err_checksum = err_ck_q;
  assign data_out     = data_q;
`ifdef DHT_AUTO_RETRY_EN
  assign retry_cnt    = retry_q;
`endif

endmodule

// File: tb/tb_dht_transaction_ctrl.sv
// Scoreboard bench for dht_transaction_ctrl with a behavioural DHT sensor model.
module tb_dht_transaction_ctrl;

  localparam int unsigned TPU = 2;
  localparam int unsigned NB  = 40;
  localparam logic [NB-1:0] GOOD = 40'h37_00_19_00_50;
  localparam logic [NB-1:0] BADF = 40'h37_00_19_00_51;
`ifdef DHT_AUTO_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sens = 1'b1;
  logic dq_in, dq_oe, busy, done, err_timeout, err_checksum;
  logic [NB-1:0] data_out;
`ifdef DHT_AUTO_RETRY_EN
  logic [1:0] retry_cnt;
`endif

  assign dq_in = sens & ~dq_oe;
  always #5 clk = ~clk;

  dht_transaction_ctrl #(
    .TICK_PER_US(TPU),
    .START_LOW_US(100),
    .RESP_TIMEOUT_US(200),
    .NUM_BITS(NB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dq_in(dq_in),
    .dq_oe(dq_oe),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout),
    .err_checksum(err_checksum),
`ifdef DHT_AUTO_RETRY_EN
    .retry_cnt(retry_cnt),
`endif
    .data_out(data_out)
  );

  typedef struct {
    logic [NB-1:0] data;
    logic          et;
    logic          ec;
    int            rc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int oe_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [NB-1:0] d, input logic et, input logic ec, input int rc);
    exp_t e;
    e.data = d; e.et = et; e.ec = ec; e.rc = rc;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse is matched against the oldest expected outcome.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: done=1 with no transaction outstanding");
        end else begin
          e = exp_q.pop_front();
          check("err_timeout", err_timeout, e.et);
          check("err_checksum", err_checksum, e.ec);
`ifdef DHT_AUTO_RETRY_EN
          check("retry_cnt", retry_cnt, e.rc);
`endif
          @(negedge clk);
          check("data_out", data_out, e.data);
          check("busy_after_done", busy, 0);
          check("done_single_cycle", done, 0);
        end
      end
    end
  end

  initial begin : oe_monitor
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (dq_oe) run++;
      else if (run != 0) begin
        oe_pulses++;
        check("start_low_cycles", run, 100 * TPU);
        run = 0;
      end
    end
  end

  initial begin : watchdog
    repeat (300000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic wait_us(input int us);
    repeat (us * TPU) @(negedge clk);
  endtask

  task automatic wait_oe(input logic v);
    int n;
    n = 0;
    while (dq_oe !== v && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (dq_oe !== v) begin
      total++; bad++;
      $display("FAIL wait_dq_oe: dq_oe=%b required %b within budget", dq_oe, v);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL wait_idle: busy=%b required 0 within budget", busy);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    check("busy_before_start", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("dq_oe_after_start", dq_oe, 1);
  endtask

  // Sensor model: responds 80/80 us, then bits as 50 us low + 27/70 us high.
  // abort_bit >= 0 resets the DUT partway through that bit's high phase.
  task automatic send_frame(input logic [NB-1:0] f, input int abort_bit);
    wait_oe(1'b1);
    wait_oe(1'b0);
    wait_us(40);
    sens = 1'b0; wait_us(80);
    sens = 1'b1; wait_us(80);
    for (int i = 0; i < NB; i++) begin
      sens = 1'b0; wait_us(50);
      sens = 1'b1;
      if (i == abort_bit) begin
        wait_us(10);
        check("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_dq_oe", dq_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data_out", data_out, 0);
        return;
      end
      wait_us(f[NB-1-i] ? 70 : 27);
    end
    sens = 1'b0; wait_us(50);
    sens = 1'b1;
  endtask

  initial begin : stimulus
    int pulses0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dq_oe", dq_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err_timeout", err_timeout, 0);
    check("reset_err_checksum", err_checksum, 0);
    check("reset_data_out", data_out, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame
    push_exp(GOOD, 1'b0, 1'b0, 0);
    pulse_start();
    send_frame(GOOD, -1);
    wait_idle();

    // Bad checksum (every attempt in the retry build)
    push_exp(BADF, 1'b0, 1'b1, ATTEMPTS - 1);
    pulse_start();
    for (int a = 0; a < ATTEMPTS; a++) send_frame(BADF, -1);
    wait_idle();

    // Silent sensor: data_out keeps the previous frame
    push_exp(BADF, 1'b1, 1'b0, ATTEMPTS - 1);
    pulse_start();
    wait_idle();

    // Reset during BIT_HIGH of bit 17, then a clean frame
    pulse_start();
    send_frame(GOOD, 17);
    wait_us(5);
    sens = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_busy", busy, 0);
    push_exp(GOOD, 1'b0, 1'b0, 0);
    pulse_start();
    send_frame(GOOD, -1);
    wait_idle();

`ifdef DHT_AUTO_RETRY_EN
    // First attempt silent, second good
    pulses0 = oe_pulses;
    push_exp(GOOD, 1'b0, 1'b0, 1);
    pulse_start();
    wait_oe(1'b1);
    wait_oe(1'b0);
    send_frame(GOOD, -1);
    wait_idle();
    check("retry_start_low_count", oe_pulses - pulses0, 2);
`else
    pulses0 = oe_pulses;
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
